cla_accum16: RTL and testbench

Sequential operand accumulator that sits on both sides of the team's 16-bit two-level carry-lookahead adder. It feeds the adder's two operand inputs and consumes its sum and carry-out. It sums a stream of `len` 16-bit operands, one per cycle, into a 16-bit accumulator plus a carry counter. It then presents the extended result `{carry_cnt, acc}` on a valid/ready output. The adder stays external and purely combinational; this block owns all state.

---
 rtl/cla_accum16_if.sv | 29 ++
 rtl/cla_accum16.sv | 83 ++++++++
 tb/tb_cla_accum16.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/cla_accum16_if.sv
// Bundle of the accumulator's control, operand, adder and result signals.
// The slave side is the accumulator; the master side is the surrounding logic and adder.
interface cla_accum16_if #(
    parameter int LEN_W = 8
);
    logic                  start;
    logic [LEN_W-1:0]      len;
    logic                  busy;
    logic                  in_valid;
    logic [15:0]           in_data;
    logic                  in_ready;
    logic [15:0]           add_op1;
    logic [15:0]           add_op2;
    logic [15:0]           add_sum;
    logic                  add_cout;
    logic                  res_valid;
    logic [16+LEN_W-1:0]   res_data;
    logic                  res_ready;

    modport slave (
        input  start, len, in_valid, in_data, add_sum, add_cout, res_ready,
        output busy, in_ready, add_op1, add_op2, res_valid, res_data
    );

    modport master (
        output start, len, in_valid, in_data, add_sum, add_cout, res_ready,
        input  busy, in_ready, add_op1, add_op2, res_valid, res_data
    );
endinterface

// File: rtl/cla_accum16.sv
// Streams len 16-bit operands through an external combinational adder into
// acc plus a carry counter, then offers {carry_cnt, acc} on a valid/ready port.
module cla_accum16 #(
    parameter int LEN_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    cla_accum16_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [LEN_W-1:0] carry_q, carry_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;

    // NOTE: every state register uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            carry_q <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: hold-by-default assignments up front keep this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        rem_d   = rem_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    carry_d = '0;
                    rem_d   = bus.len;
                    state_d = (bus.len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                // in_ready is high throughout ACCUM, so in_valid alone marks a transfer
                if (bus.in_valid) begin
                    acc_d   = bus.add_sum;
                    carry_d = carry_q + LEN_W'(bus.add_cout);
                    rem_d   = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.busy      = busy_q;
    assign bus.in_ready  = (state_q == S_ACCUM);
    assign bus.res_valid = (state_q == S_DONE);
    assign bus.res_data  = {carry_q, acc_q};
    assign bus.add_op1   = acc_q;
    assign bus.add_op2   = (state_q == S_ACCUM) ? bus.in_data : 16'h0000;
endmodule

// File: tb/tb_cla_accum16.sv
// Bench for cla_accum16: plain-arithmetic reference sums, per-cycle output
// checks against them, and directed scenarios with literal results.
`timescale 1ns/1ps
module tb_cla_accum16;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cla_accum16_if #(.LEN_W(LEN_W)) bus ();

    cla_accum16 #(.LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in for the external carry-lookahead adder
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_op1} + {1'b0, bus.add_op2};

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_q[$];
    logic [15:0] ops[$];
    logic [15:0] model_acc = 16'h0000;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: running sum of accepted operands and queue of expected results
    always @(posedge clk) begin
        if (rst) begin
            model_acc = 16'h0000;
        end else begin
            if (!bus.busy && bus.start) model_acc = 16'h0000;
            else if (bus.in_valid && bus.in_ready) model_acc = model_acc + bus.in_data;
            if (bus.res_valid && bus.res_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    // Every-cycle output comparison, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            check("busy_vs_phase", bus.busy, bus.in_ready | bus.res_valid);
            check("ready_valid_excl", bus.in_ready & bus.res_valid, 0);
            check("add_op1", bus.add_op1, model_acc);
            check("add_op2", bus.add_op2, bus.in_ready ? bus.in_data : 16'h0000);
            if (bus.res_valid) begin
                if (exp_q.size() == 0) check("res_unexpected", bus.res_valid, 0);
                else check("res_data", bus.res_data, exp_q[0]);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sum(input int gap_max, input int stall, input bit has_lit, input logic [23:0] lit);
        logic [23:0] total;
        int n;
        int gaps;
        total = '0;
        n = ops.size();
        foreach (ops[i]) total = total + 24'(ops[i]);
        exp_q.push_back(total);

        bus.start = 1'b1;
        bus.len   = LEN_W'(n);
        next_cycle();
        bus.start = 1'b0;
        bus.len   = LEN_W'($urandom);
        if (n == 0) begin
            check("len0_res_valid", bus.res_valid, 1);
            check("len0_in_ready", bus.in_ready, 0);
        end else begin
            check("start_lat_in_ready", bus.in_ready, 1);
        end

        for (int i = 0; i < n; i++) begin
            gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            repeat (gaps) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 16'($urandom);
                bus.start    = 1'($urandom_range(0, 1));
                next_cycle();
            end
            bus.start    = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data  = ops[i];
            check("in_ready_before_xfer", bus.in_ready, 1);
            next_cycle();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        if (n > 0) begin
            check("res_lat_valid", bus.res_valid, 1);
            check("res_lat_in_ready", bus.in_ready, 0);
        end

        // start is asserted throughout DONE, including the handshake edge
        repeat (stall) begin
            bus.res_ready = 1'b0;
            bus.start     = 1'b1;
            bus.len       = LEN_W'(5);
            next_cycle();
            check("done_hold_valid", bus.res_valid, 1);
        end
        if (has_lit) check("res_literal", bus.res_data, lit);
        bus.res_ready = 1'b1;
        bus.start     = 1'b1;
        bus.len       = LEN_W'(5);
        next_cycle();
        bus.res_ready = 1'b0;
        bus.start     = 1'b0;
        check("busy_after_hs", bus.busy, 0);
        check("res_valid_after_hs", bus.res_valid, 0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'hA5A5;
        bus.res_ready = 1'b0;
        rst           = 1'b1;
        next_cycle();
        next_cycle();
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_add_op1", bus.add_op1, 0);
        check("rst_add_op2", bus.add_op2, 0);
        rst = 1'b0;
        next_cycle();

        ops = '{16'h0001, 16'h0002, 16'h0003};
        do_sum(0, 0, 1'b1, 24'h000006);

        ops = '{16'hFFFF, 16'h0001};
        do_sum(0, 0, 1'b1, 24'h010000);

        ops.delete();
        repeat (255) ops.push_back(16'hFFFF);
        do_sum(0, 0, 1'b1, 24'hFEFF01);

        ops.delete();
        do_sum(0, 2, 1'b1, 24'h000000);

        // Two 0x8000 operands with a three-cycle input gap, five stalled result cycles
        bus.start = 1'b1;
        bus.len   = LEN_W'(2);
        exp_q.push_back(24'h010000);
        next_cycle();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h8000;
        next_cycle();
        bus.in_valid = 1'b0;
        repeat (3) next_cycle();
        check("gap_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        next_cycle();
        bus.in_valid = 1'b0;
        ops.delete();
        exp_q.delete();
        exp_q.push_back(24'h010000);
        repeat (5) begin
            bus.start = 1'b1;
            next_cycle();
            check("bp_res_data", bus.res_data, 24'h010000);
        end
        ops.delete();
        void'(exp_q.pop_front());
        // Finish via do_sum-style handshake by hand
        exp_q.push_back(24'h010000);
        bus.res_ready = 1'b1;
        bus.start     = 1'b1;
        next_cycle();
        bus.res_ready = 1'b0;
        bus.start     = 1'b0;
        check("bp_busy_after_hs", bus.busy, 0);

        // Reset in the middle of a four-operand sum
        bus.start = 1'b1;
        bus.len   = LEN_W'(4);
        next_cycle();
        bus.start = 1'b0;
        repeat (2) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'($urandom);
            next_cycle();
        end
        rst = 1'b1;
        next_cycle();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_res_valid", bus.res_valid, 0);
        check("abort_res_data", bus.res_data, 0);
        check("abort_add_op1", bus.add_op1, 0);
        check("abort_add_op2", bus.add_op2, 0);
        repeat (5) next_cycle();
        ops = '{16'h1234};
        do_sum(0, 0, 1'b1, 24'h001234);

        // Randomized sums with input gaps and result backpressure
        repeat (30) begin
            ops.delete();
            repeat ($urandom_range(0, 20)) begin
                if ($urandom_range(0, 1) != 0) ops.push_back(16'hF000 | 16'($urandom));
                else ops.push_back(16'($urandom));
            end
            do_sum(3, $urandom_range(0, 3), 1'b0, 24'h0);
        end

        repeat (3) next_cycle();
        check("results_outstanding", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
